flag_branch_ctrl: RTL and testbench
===================================

FLAG_BRANCH_CTRL -- requirements
Module: flag_branch_ctrl

Interface
REQ-001 SHALL have parameter IMM_W, default 9: width of the signed PC-relative branch offset, counted in half-words.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port stall, input, 1 bit: when 1, all internal state holds.
REQ-005 SHALL have port flag_wr_en, input, 3 bits: per-flag write enables as {Z,V,N}.
REQ-006 SHALL have ports alu_N, alu_Z and alu_V, each input, 1 bit: flags from the 16-bit add/sub unit.
REQ-007 SHALL have port br_valid, input, 1 bit: a branch is presented this cycle.
REQ-008 SHALL have port br_cond, input, 3 bits: condition code ccc.
REQ-009 SHALL have port br_reg, input, 1 bit: 0 selects a PC-relative target, 1 selects a register target.
REQ-010 SHALL have port br_imm, input, IMM_W bits: signed offset in half-words.
REQ-011 SHALL have port reg_target, input, 16 bits: register branch target.
REQ-012 SHALL have port pc_plus2, input, 16 bits: address of the branch plus 2.
REQ-013 SHALL have port halt, input, 1 bit: a HLT instruction is presented.
REQ-014 SHALL have port flags, output, 3 bits: registered {Z,V,N}.
REQ-015 SHALL have ports out_valid, taken and halted, each output, 1 bit, all registered.
REQ-016 SHALL have port next_pc, output, 16 bits, registered resolved PC.

Function
REQ-017 SHALL implement FSM states RUN and HALTED; on RUN with halt=1 and stall=0, the FSM SHALL move to HALTED on the next edge; HALTED SHALL exit only via rst.
REQ-018 In RUN with stall=0, each flag SHALL load its alu_* value when its enable bit is 1 and SHALL hold otherwise; flag enables are independent.
REQ-019 Branch evaluation SHALL use the flag register value before the current edge; a flag write in the same cycle as a branch SHALL affect only later branches.
REQ-020 Conditions SHALL be: 000 NE (Z=0); 001 EQ (Z=1); 010 GT (Z=0 and N=0); 011 LT (N=1); 100 GTE (Z=1 or N=0); 101 LTE (N=1 or Z=1); 110 OVFL (V=1); 111 always.
REQ-021 The PC-relative target SHALL be pc_plus2 + (sign-extended br_imm << 1), truncated to 16 bits; wrap-around is legal (0xFFFE + 4 = 0x0002).
REQ-022 The register target SHALL be reg_target, used unmodified.
REQ-023 Latency SHALL be one cycle: br_valid=1 in RUN with stall=0 SHALL yield out_valid=1 on the next cycle.
REQ-024 On that resolved cycle, taken SHALL equal the condition result, and next_pc SHALL be the target if taken, else pc_plus2.
REQ-025 With br_valid=0 and stall=0 in RUN, out_valid and taken SHALL be 0 on the next cycle, and next_pc SHALL hold.
REQ-026 When stall=1, out_valid, taken, next_pc, flags and the FSM SHALL all hold their values.
REQ-027 If halt and br_valid are both 1, halt SHALL win: no branch is resolved and out_valid=0.
REQ-028 In HALTED, halted SHALL be 1, out_valid and taken SHALL be 0, flags and next_pc SHALL be frozen, and all inputs except rst SHALL be ignored.

Reset
REQ-029 On rst=1 at an edge, flags SHALL be 000, out_valid, taken and halted SHALL be 0, next_pc SHALL be 0x0000, and the FSM SHALL be in RUN.
REQ-030 rst SHALL take priority over stall, halt and br_valid, and SHALL abort an in-flight branch result.

Verification
REQ-031 Bench SHALL cover: flag_wr_en=111, Z=1 N=0 V=0, then next cycle br_cond=001, br_imm=+4, pc_plus2=0x0010 -> one cycle later out_valid=1, taken=1, next_pc=0x0018.
REQ-032 Bench SHALL cover: flags Z=0 N=1, br_cond=010, pc_plus2=0x0020 -> taken=0, next_pc=0x0020; then br_cond=011 -> taken=1.
REQ-033 Bench SHALL cover: flag write Z=1 in the same cycle as br_cond=001 with old Z=0 -> taken=0; an identical branch next cycle -> taken=1.
REQ-034 Bench SHALL cover: br_imm=-1, pc_plus2=0x0000, br_cond=111 -> next_pc=0xFFFE; br_reg=1, reg_target=0x1234 -> next_pc=0x1234.
REQ-035 Bench SHALL cover: stall=1 held for 3 cycles around a pending branch -> outputs frozen and the result appears exactly once after stall releases.
REQ-036 Bench SHALL cover: halt=1 together with br_valid=1 -> halted=1, out_valid=0 and flags frozen while flag_wr_en=111; then rst=1 -> all outputs return to reset values.

Source files
------------

// File: rtl/flag_branch_ctrl.sv
// flag_branch_ctrl
//   Holds the {Z,V,N} condition flags written by the 16-bit add/sub unit and
//   resolves conditional branches against them with one cycle of latency.
//   A HLT instruction parks the block in HALTED until reset.
//
// Handshake: a branch is accepted on a rising edge when br_valid=1, stall=0,
//   halt=0 and the FSM is in RUN. Its result (out_valid=1 with taken and
//   next_pc) is presented for the following cycle(s) until the next
//   non-stalled edge. There is no back-pressure from the consumer; stall
//   freezes both the request side and the registered result.
//
// Ports
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   stall       in   hold all internal state
//   flag_wr_en  in   [2:0] per-flag write enables {Z,V,N}
//   alu_n/z/v   in   flag values from the add/sub unit
//   br_valid    in   branch presented this cycle
//   br_cond     in   [2:0] condition code
//   br_reg      in   0: PC-relative target, 1: register target
//   br_imm      in   [IMM_W-1:0] signed offset in half-words
//   reg_target  in   [15:0] register branch target
//   pc_plus2    in   [15:0] branch address + 2
//   halt        in   HLT instruction presented
//   flags       out  [2:0] registered {Z,V,N}
//   out_valid   out  registered: branch result valid
//   taken       out  registered: branch taken
//   halted      out  registered: FSM is HALTED (doubles as the FSM state view)
//   next_pc     out  [15:0] registered resolved PC
module flag_branch_ctrl #(
    parameter int IMM_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic [2:0]       flag_wr_en,
    input  logic             alu_N,
    input  logic             alu_Z,
    input  logic             alu_V,
    input  logic             br_valid,
    input  logic [2:0]       br_cond,
    input  logic             br_reg,
    input  logic [IMM_W-1:0] br_imm,
    input  logic [15:0]      reg_target,
    input  logic [15:0]      pc_plus2,
    input  logic             halt,
    output logic [2:0]       flags,
    output logic             out_valid,
    output logic             taken,
    output logic             halted,
    output logic [15:0]      next_pc
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state, state_n;
    logic [2:0]  flags_n;
    logic        out_valid_n;
    logic        taken_n;
    logic [15:0] next_pc_n;

    logic        cond_ok;
    logic [15:0] imm_ext;
    logic [15:0] target;

    // Flag bit positions inside {Z,V,N}
    logic fz, fv, fn;
    assign fz = flags[2];
    assign fv = flags[1];
    assign fn = flags[0];

    // Condition evaluation uses the registered flags, so a flag write in the
    // same cycle as a branch only affects later branches.
    always_comb begin
        cond_ok = 1'b0;
        case (br_cond)
            3'b000:  cond_ok = ~fz;
            3'b001:  cond_ok = fz;
            3'b010:  cond_ok = ~fz & ~fn;
            3'b011:  cond_ok = fn;
            3'b100:  cond_ok = fz | ~fn;
            3'b101:  cond_ok = fn | fz;
            3'b110:  cond_ok = fv;
            default: cond_ok = 1'b1;
        endcase
    end

    // Sign-extend the half-word offset to 16 bits, then scale to bytes.
    // IMM_W is expected to be below 16.
    assign imm_ext = {{(16 - IMM_W){br_imm[IMM_W-1]}}, br_imm};
    assign target  = br_reg ? reg_target
                            : pc_plus2 + {imm_ext[14:0], 1'b0};

    always_comb begin
        state_n     = state;
        flags_n     = flags;
        out_valid_n = out_valid;
        taken_n     = taken;
        next_pc_n   = next_pc;

        if (state == RUN && !stall) begin
            flags_n[2] = flag_wr_en[2] ? alu_Z : flags[2];
            flags_n[1] = flag_wr_en[1] ? alu_V : flags[1];
            flags_n[0] = flag_wr_en[0] ? alu_N : flags[0];

            if (halt) begin
                // HLT beats a simultaneous branch: nothing is resolved.
                state_n     = HALTED;
                out_valid_n = 1'b0;
                taken_n     = 1'b0;
            end else if (br_valid) begin
                out_valid_n = 1'b1;
                taken_n     = cond_ok;
                next_pc_n   = cond_ok ? target : pc_plus2;
            end else begin
                out_valid_n = 1'b0;
                taken_n     = 1'b0;
            end
        end
        // In HALTED everything holds; out_valid/taken were cleared on entry.
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            flags     <= 3'b000;
            out_valid <= 1'b0;
            taken     <= 1'b0;
            next_pc   <= 16'h0000;
        end else begin
            state     <= state_n;
            flags     <= flags_n;
            out_valid <= out_valid_n;
            taken     <= taken_n;
            next_pc   <= next_pc_n;
        end
    end

    assign halted = (state == HALTED);

endmodule

// File: tb/tb_flag_branch_ctrl.sv
module tb_flag_branch_ctrl;

  localparam int IMM_W = 9;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             stall;
  logic [2:0]       flag_wr_en;
  logic             alu_N, alu_Z, alu_V;
  logic             br_valid;
  logic [2:0]       br_cond;
  logic             br_reg;
  logic [IMM_W-1:0] br_imm;
  logic [15:0]      reg_target;
  logic [15:0]      pc_plus2;
  logic             halt;
  logic [2:0]       flags;
  logic             out_valid, taken, halted;
  logic [15:0]      next_pc;

  int total  = 0;
  int passed = 0;

  flag_branch_ctrl #(.IMM_W(IMM_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flag_wr_en(flag_wr_en),
    .alu_N(alu_N), .alu_Z(alu_Z), .alu_V(alu_V),
    .br_valid(br_valid), .br_cond(br_cond), .br_reg(br_reg),
    .br_imm(br_imm), .reg_target(reg_target), .pc_plus2(pc_plus2),
    .halt(halt), .flags(flags), .out_valid(out_valid), .taken(taken),
    .halted(halted), .next_pc(next_pc)
  );

  // ---------------- driver tasks ----------------
  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; flag_wr_en = 3'b000; alu_N = 0; alu_Z = 0; alu_V = 0;
    br_valid = 0; br_cond = 3'b000; br_reg = 0; br_imm = '0;
    reg_target = 16'h0000; pc_plus2 = 16'h0000; halt = 0;
  endtask

  task automatic set_flags(input logic [2:0] en, input logic z, input logic v, input logic n);
    flag_wr_en = en; alu_Z = z; alu_V = v; alu_N = n;
  endtask

  task automatic branch(input logic [2:0] cond, input logic use_reg,
                        input logic [IMM_W-1:0] imm, input logic [15:0] rt,
                        input logic [15:0] pc);
    br_valid = 1; br_cond = cond; br_reg = use_reg; br_imm = imm;
    reg_target = rt; pc_plus2 = pc;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_res(input string tag, input logic v, input logic t, input logic [15:0] pc);
    chk({tag, "_valid"}, {15'd0, out_valid}, {15'd0, v});
    chk({tag, "_taken"}, {15'd0, taken}, {15'd0, t});
    chk({tag, "_pc"}, next_pc, pc);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;

    // Reset state
    chk("rst_flags", {13'd0, flags}, 16'h0000);
    chk("rst_halted", {15'd0, halted}, 16'h0000);
    chk_res("rst", 1'b0, 1'b0, 16'h0000);

    // Write Z=1 V=0 N=0, then EQ branch +4 half-words from 0x0010
    set_flags(3'b111, 1, 0, 0);
    tick();
    chk("wr_zvn", {13'd0, flags}, 16'h0004);
    chk("wr_no_valid", {15'd0, out_valid}, 16'h0000);
    set_flags(3'b000, 0, 0, 0);
    branch(3'b001, 0, 9'd4, 16'h0000, 16'h0010);
    tick();
    chk_res("eq_taken", 1'b1, 1'b1, 16'h0018);

    // No branch: result drops, next_pc holds
    br_valid = 0;
    tick();
    chk_res("idle_hold", 1'b0, 1'b0, 16'h0018);

    // Z=0 N=1: GT not taken, then LT taken
    set_flags(3'b111, 0, 0, 1);
    tick();
    chk("wr_n", {13'd0, flags}, 16'h0001);
    set_flags(3'b000, 0, 0, 0);
    branch(3'b010, 0, 9'd4, 16'h0000, 16'h0020);
    tick();
    chk_res("gt_not", 1'b1, 1'b0, 16'h0020);
    branch(3'b011, 0, 9'd4, 16'h0000, 16'h0020);
    tick();
    chk_res("lt_taken", 1'b1, 1'b1, 16'h0028);

    // Same-cycle Z write does not affect this branch, only the next one;
    // only Z is enabled so V/N inputs must be ignored.
    set_flags(3'b100, 1, 1, 0);
    branch(3'b001, 0, 9'd4, 16'h0000, 16'h0030);
    tick();
    chk_res("eq_old_z", 1'b1, 1'b0, 16'h0030);
    chk("wr_z_only", {13'd0, flags}, 16'h0005);
    set_flags(3'b000, 0, 0, 0);
    tick();
    chk_res("eq_new_z", 1'b1, 1'b1, 16'h0038);

    // Flags Z=1 V=0 N=1: NE not taken, GTE taken (Z=1), LTE taken
    branch(3'b000, 0, 9'd4, 16'h0000, 16'h0040);
    tick();
    chk_res("ne_not", 1'b1, 1'b0, 16'h0040);
    branch(3'b100, 0, 9'd2, 16'h0000, 16'h0040);
    tick();
    chk_res("gte_taken", 1'b1, 1'b1, 16'h0044);
    branch(3'b101, 0, 9'd1, 16'h0000, 16'h0040);
    tick();
    chk_res("lte_taken", 1'b1, 1'b1, 16'h0042);

    // Negative offset, wrap-around, register target
    branch(3'b111, 0, 9'h1FF, 16'h0000, 16'h0000);
    tick();
    chk_res("neg_wrap", 1'b1, 1'b1, 16'hFFFE);
    branch(3'b111, 0, 9'd2, 16'h0000, 16'hFFFE);
    tick();
    chk_res("pos_wrap", 1'b1, 1'b1, 16'h0002);
    branch(3'b111, 1, 9'd4, 16'h1234, 16'h0050);
    tick();
    chk_res("reg_tgt", 1'b1, 1'b1, 16'h1234);
    branch(3'b111, 0, 9'h100, 16'h0000, 16'h0000);
    tick();
    chk_res("min_imm", 1'b1, 1'b1, 16'hFE00);

    // OVFL: V written alongside the branch, seen only next cycle
    set_flags(3'b010, 0, 1, 0);
    branch(3'b110, 1, 9'd0, 16'h0BAD, 16'h0060);
    tick();
    chk_res("ovfl_old", 1'b1, 1'b0, 16'h0060);
    chk("wr_v", {13'd0, flags}, 16'h0007);
    set_flags(3'b000, 0, 0, 0);
    tick();
    chk_res("ovfl_new", 1'b1, 1'b1, 16'h0BAD);

    // Stall around a pending branch
    br_valid = 0;
    tick();
    chk_res("pre_stall", 1'b0, 1'b0, 16'h0BAD);
    stall = 1;
    halt = 1;
    set_flags(3'b111, 0, 0, 0);
    branch(3'b111, 1, 9'd0, 16'hBEEF, 16'h0070);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_res("stalled", 1'b0, 1'b0, 16'h0BAD);
      chk("stall_flags", {13'd0, flags}, 16'h0007);
      chk("stall_halt", {15'd0, halted}, 16'h0000);
    end
    stall = 0;
    halt = 0;
    set_flags(3'b000, 0, 0, 0);
    tick();
    chk_res("release", 1'b1, 1'b1, 16'hBEEF);
    br_valid = 0;
    stall = 1;
    tick();
    chk_res("stall_hold_res", 1'b1, 1'b1, 16'hBEEF);
    stall = 0;
    tick();
    chk_res("once_only", 1'b0, 1'b0, 16'hBEEF);

    // Halt wins over a simultaneous branch
    halt = 1;
    branch(3'b111, 1, 9'd0, 16'h5555, 16'h0080);
    tick();
    chk("halt_state", {15'd0, halted}, 16'h0001);
    chk_res("halt_nobr", 1'b0, 1'b0, 16'hBEEF);
    halt = 0;
    set_flags(3'b111, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("halted_stays", {15'd0, halted}, 16'h0001);
      chk("halted_flags", {13'd0, flags}, 16'h0007);
      chk_res("halted_out", 1'b0, 1'b0, 16'hBEEF);
    end

    // Reset beats everything, including a presented branch
    rst = 1;
    stall = 1;
    halt = 1;
    tick();
    chk("rst2_flags", {13'd0, flags}, 16'h0000);
    chk("rst2_halted", {15'd0, halted}, 16'h0000);
    chk_res("rst2", 1'b0, 1'b0, 16'h0000);

    // Back in RUN: branches resolve again
    rst = 0;
    stall = 0;
    halt = 0;
    set_flags(3'b000, 0, 0, 0);
    branch(3'b111, 1, 9'd0, 16'h4444, 16'h0090);
    tick();
    chk_res("after_rst", 1'b1, 1'b1, 16'h4444);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Safety bound on total runtime
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
